// File: rtl/hub_slot_sequencer.sv
// hub_slot_sequencer
// Hub timing and select logic for a parameterised number of cogs.
// It produces the free-running system counter and the hub slot strobe.
// It rotates a one-hot slot owner through the cogs, and in skip-idle mode
// it passes over cogs that are not enabled. The owner's hub request is
// muxed into one registered hub transaction, and the owning cog receives
// a single-cycle ack.
//
// Ports:
//   clk_cog  - cog clock; all state changes on the rising edge
//   res      - synchronous reset, active high
//   cog_ena  - per-cog running flags
//   req      - per-cog hub request, held by the cog until it is acked
//   req_w    - per-cog write (1) / read (0)
//   req_a    - per-cog address, cog i at [i*A_W +: A_W]
//   req_d    - per-cog write data, cog i at [i*D_W +: D_W]
//   cnt      - free-running system counter
//   ena_bus  - high on the last clock of each slot
//   bus_sel  - one-hot current slot owner, 0 when there is no owner
//   hub_v    - one-cycle strobe when a transaction is issued
//   hub_w    - issued transaction is a write
//   hub_a    - issued address
//   hub_d    - issued write data
//   ack      - one-cycle ack to the granted cog
module hub_slot_sequencer #(
  parameter int NUMCOGS   = 8,
  parameter int SLOT_CLKS = 2,
  parameter int SKIP_IDLE = 0,
  parameter int CNT_W     = 32,
  parameter int A_W       = 16,
  parameter int D_W       = 32
) (
  input  logic                   clk_cog,
  input  logic                   res,
  input  logic [NUMCOGS-1:0]     cog_ena,
  input  logic [NUMCOGS-1:0]     req,
  input  logic [NUMCOGS-1:0]     req_w,
  input  logic [NUMCOGS*A_W-1:0] req_a,
  input  logic [NUMCOGS*D_W-1:0] req_d,
  output logic [CNT_W-1:0]       cnt,
  output logic                   ena_bus,
  output logic [NUMCOGS-1:0]     bus_sel,
  output logic                   hub_v,
  output logic                   hub_w,
  output logic [A_W-1:0]         hub_a,
  output logic [D_W-1:0]         hub_d,
  output logic [NUMCOGS-1:0]     ack
);

  localparam int TW = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(SLOT_CLKS - 1);

  logic [TW-1:0]      tmr;
  logic [NUMCOGS-1:0] next_sel;
  logic [NUMCOGS-1:0] grant_vec;
  logic               sel_w;
  logic [A_W-1:0]     sel_a;
  logic [D_W-1:0]     sel_d;
  int                 owner_idx;
  int                 start_idx;
  int                 probe_idx;
  logic               found;

  assign ena_bus = (tmr == TMR_LAST) && !res;

  // bus_sel is one-hot, so masking it with req and cog_ena yields the
  // ack pattern directly. That pattern is nonzero only for a grantable owner.
  assign grant_vec = bus_sel & req & cog_ena;

  // Decode the owner index and select its request fields.
  always_comb begin
    owner_idx = 0;
    sel_w     = 1'b0;
    sel_a     = '0;
    sel_d     = '0;
    for (int i = 0; i < NUMCOGS; i++) begin
      if (bus_sel[i]) begin
        owner_idx = i;
        sel_w     = req_w[i];
        sel_a     = req_a[i*A_W +: A_W];
        sel_d     = req_d[i*D_W +: D_W];
      end
    end
  end

  // Next slot owner. In skip-idle mode the search runs cyclically from
  // owner+1, so the current owner is only picked again when it is the
  // sole enabled cog.
  always_comb begin
    next_sel  = '0;
    start_idx = 0;
    probe_idx = 0;
    found     = 1'b0;
    if (SKIP_IDLE == 0) begin
      if (bus_sel == '0 || bus_sel[NUMCOGS-1]) next_sel = NUMCOGS'(1);
      else next_sel = bus_sel << 1;
    end else begin
      start_idx = (bus_sel == '0) ? 0 : (owner_idx + 1) % NUMCOGS;
      for (int k = 0; k < NUMCOGS; k++) begin
        probe_idx = (start_idx + k) % NUMCOGS;
        if (!found && cog_ena[probe_idx]) begin
          next_sel[probe_idx] = 1'b1;
          found               = 1'b1;
        end
      end
    end
  end

  // Counter, slot timer, owner rotation and the registered hub transaction.
  // hub_w/a/d keep their value between grants. hub_v and ack are pulses.
  always_ff @(posedge clk_cog) begin
    if (res) begin
      cnt     <= '0;
      tmr     <= '0;
      bus_sel <= '0;
      hub_v   <= 1'b0;
      hub_w   <= 1'b0;
      hub_a   <= '0;
      hub_d   <= '0;
      ack     <= '0;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      tmr   <= (tmr == TMR_LAST) ? '0 : tmr + TW'(1);
      hub_v <= 1'b0;
      ack   <= '0;
      if (ena_bus) begin
        bus_sel <= next_sel;
        if (|grant_vec) begin
          hub_v <= 1'b1;
          ack   <= grant_vec;
          hub_w <= sel_w;
          hub_a <= sel_a;
          hub_d <= sel_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_hub_slot_sequencer.sv
// tb_hub_slot_sequencer
// This bench drives two sequencer instances from shared random request
// traffic. Instance 0 uses the defaults: 8 cogs, 2-clock slots and full
// rotation. Instance 1 uses 8 cogs, 3-clock slots, skip-idle rotation and
// a 4-bit counter. A behavioural model predicts every output cycle by cycle.
module tb_hub_slot_sequencer;

  localparam int N = 8;

  logic           clk_cog = 1'b0;
  logic           res;
  logic [N-1:0]   cog_ena0, cog_ena1;
  logic [N-1:0]   req, req_w;
  logic [N*16-1:0] req_a;
  logic [N*32-1:0] req_d;

  logic [31:0] cnt0;
  logic [3:0]  cnt1;
  logic        ena_bus0, ena_bus1, hub_v0, hub_v1, hub_w0, hub_w1;
  logic [N-1:0] bus_sel0, bus_sel1, ack0, ack1;
  logic [15:0] hub_a0, hub_a1;
  logic [31:0] hub_d0, hub_d1;

  int checks = 0;
  int errors = 0;

  // Per-instance model state: cycles since reset, owner index (-1 = none),
  // and the last issued transaction.
  int          slot_len [2] = '{2, 3};
  int          skip     [2] = '{0, 1};
  int          cnt_bits [2] = '{32, 4};
  int          t        [2];
  int          own      [2];
  int          m_ack    [2];
  logic        m_v      [2];
  logic        m_w      [2];
  logic [15:0] m_a      [2];
  logic [31:0] m_d      [2];

  hub_slot_sequencer dut0 (
    .clk_cog(clk_cog), .res(res), .cog_ena(cog_ena0), .req(req), .req_w(req_w),
    .req_a(req_a), .req_d(req_d), .cnt(cnt0), .ena_bus(ena_bus0), .bus_sel(bus_sel0),
    .hub_v(hub_v0), .hub_w(hub_w0), .hub_a(hub_a0), .hub_d(hub_d0), .ack(ack0)
  );

  hub_slot_sequencer #(.NUMCOGS(8), .SLOT_CLKS(3), .SKIP_IDLE(1), .CNT_W(4)) dut1 (
    .clk_cog(clk_cog), .res(res), .cog_ena(cog_ena1), .req(req), .req_w(req_w),
    .req_a(req_a), .req_d(req_d), .cnt(cnt1), .ena_bus(ena_bus1), .bus_sel(bus_sel1),
    .hub_v(hub_v1), .hub_w(hub_w1), .hub_a(hub_a1), .hub_d(hub_d1), .ack(ack1)
  );

  always #5 clk_cog = ~clk_cog;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance the model of instance d across one clock edge, using the
  // inputs that are present now.
  task automatic modelStep(input int d);
    logic [N-1:0] en;
    int start;
    int nxt;
    en = (d == 0) ? cog_ena0 : cog_ena1;
    if (res) begin
      t[d] = 0; own[d] = -1; m_ack[d] = -1;
      m_v[d] = 1'b0; m_w[d] = 1'b0; m_a[d] = '0; m_d[d] = '0;
      return;
    end
    m_v[d] = 1'b0;
    m_ack[d] = -1;
    if ((t[d] % slot_len[d]) == slot_len[d] - 1) begin
      if (own[d] >= 0 && req[own[d]] && en[own[d]]) begin
        m_v[d] = 1'b1;
        m_ack[d] = own[d];
        m_w[d] = req_w[own[d]];
        m_a[d] = req_a[own[d]*16 +: 16];
        m_d[d] = req_d[own[d]*32 +: 32];
      end
      if (skip[d] == 0) begin
        own[d] = (own[d] < 0 || own[d] == N - 1) ? 0 : own[d] + 1;
      end else begin
        start = (own[d] < 0) ? 0 : own[d] + 1;
        nxt = -1;
        for (int k = 0; k < N; k++)
          if (nxt < 0 && en[(start + k) % N]) nxt = (start + k) % N;
        own[d] = nxt;
      end
    end
    t[d]++;
  endtask

  task automatic checkDut(input int d, input logic [31:0] c, input logic e,
                          input logic [N-1:0] bs, input logic v, input logic w,
                          input logic [15:0] a, input logic [31:0] dd,
                          input logic [N-1:0] k);
    logic [31:0] mask;
    logic [31:0] tv;
    logic [N-1:0] exp_bs;
    logic [N-1:0] exp_ack;
    mask = (cnt_bits[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_bits[d]) - 32'd1);
    tv = 32'(t[d]);
    exp_bs = (own[d] < 0) ? '0 : (N'(1) << own[d]);
    exp_ack = (m_ack[d] < 0) ? '0 : (N'(1) << m_ack[d]);
    checkOutput($sformatf("d%0d cnt", d), 64'(c), 64'(tv & mask));
    checkOutput($sformatf("d%0d ena_bus", d), 64'(e),
                64'(!res && ((t[d] % slot_len[d]) == slot_len[d] - 1)));
    checkOutput($sformatf("d%0d bus_sel", d), 64'(bs), 64'(exp_bs));
    checkOutput($sformatf("d%0d hub_v", d), 64'(v), 64'(m_v[d]));
    checkOutput($sformatf("d%0d hub_w", d), 64'(w), 64'(m_w[d]));
    checkOutput($sformatf("d%0d hub_a", d), 64'(a), 64'(m_a[d]));
    checkOutput($sformatf("d%0d hub_d", d), 64'(dd), 64'(m_d[d]));
    checkOutput($sformatf("d%0d ack", d), 64'(k), 64'(exp_ack));
  endtask

  // Random traffic. Requests mostly persist, and the data changes at random.
  // Resets are rare. Instance 1 starts with no cog enabled and later gets
  // a changing enable mask.
  task automatic applyStimulus(input int cyc);
    res = (cyc < 2) || ($urandom_range(149, 0) == 0);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(5, 0) == 0) req[i] = ~req[i];
      if ($urandom_range(3, 0) == 0) begin
        req_w[i] = 1'($urandom);
        req_a[i*16 +: 16] = 16'($urandom);
        req_d[i*32 +: 32] = $urandom;
      end
    end
    if ($urandom_range(39, 0) == 0) cog_ena0[$urandom_range(N-1, 0)] ^= 1'b1;
    if (cyc < 40) cog_ena1 = '0;
    else if (cyc == 40) cog_ena1 = 8'b0010_0101;
    else if ($urandom_range(9, 0) == 0) cog_ena1[$urandom_range(N-1, 0)] ^= 1'b1;
    else if ($urandom_range(199, 0) == 0) cog_ena1 = '0;
  endtask

  initial begin
    res = 1'b1;
    cog_ena0 = '1;
    cog_ena1 = '0;
    req = '0; req_w = '0; req_a = '0; req_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus(cyc);
      modelStep(0);
      modelStep(1);
      @(posedge clk_cog);
      #1;
      checkDut(0, cnt0, ena_bus0, bus_sel0, hub_v0, hub_w0, hub_a0, hub_d0, ack0);
      checkDut(1, {28'd0, cnt1}, ena_bus1, bus_sel1, hub_v1, hub_w1, hub_a1, hub_d1, ack1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
